// File: rtl/ioctl_sdram_loader.sv
// rtl/ioctl_sdram_loader.sv - packs the hps_io ioctl byte stream into 16-bit SDRAM writes
// One pending word collects bytes; a single hold slot absorbs the byte that forced a flush.
module ioctl_sdram_loader #(
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_WORD = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              ram_req,
  input  logic              ram_ack,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic [1:0]        ram_be,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [26:0]       byte_count
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_FINAL, S_DONE} state_t;

  state_t            state_q;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_word_q;
  logic [15:0]       pend_data_q;
  logic [1:0]        pend_be_q;
  logic              hold_valid_q;
  logic [7:0]        hold_byte_q;
  logic              hold_lane_q;
  logic [ADDR_W-1:0] hold_word_q;
  logic              fall_q;
  logic              ram_req_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [15:0]       ram_din_q;
  logic [1:0]        ram_be_q;
  logic              wait_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;
  logic [26:0]       byte_count_q;

  logic [ADDR_W-1:0] in_word;
  logic [15:0]       merge_data;
  logic [1:0]        merge_be;

  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic [1:0] be);
    return {(be[1] ? d[15:8] : 8'h00), (be[0] ? d[7:0] : 8'h00)};
  endfunction

  assign in_word = BASE_WORD + ioctl_addr[ADDR_W:1];

  // Incoming byte merged into the pending word (pending data is zero whenever invalid).
  always_comb begin
    merge_data = pend_data_q;
    merge_be   = pend_be_q;
    if (ioctl_addr[0]) begin
      merge_data[15:8] = ioctl_dout;
      merge_be[1]      = 1'b1;
    end else begin
      merge_data[7:0]  = ioctl_dout;
      merge_be[0]      = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      pend_data_q  <= '0;
      pend_be_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_byte_q  <= '0;
      hold_lane_q  <= 1'b0;
      hold_word_q  <= '0;
      fall_q       <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_be_q     <= '0;
      wait_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      byte_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (ioctl_wr && wait_q) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (ioctl_download) begin
            byte_count_q <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_be_q    <= '0;
            hold_valid_q <= 1'b0;
            fall_q       <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (ioctl_wr) begin
            byte_count_q <= byte_count_q + 27'd1;
            if (pend_valid_q && (in_word != pend_word_q)) begin
              hold_valid_q <= 1'b1;
              hold_byte_q  <= ioctl_dout;
              hold_lane_q  <= ioctl_addr[0];
              hold_word_q  <= in_word;
              ram_req_q    <= 1'b1;
              wait_q       <= 1'b1;
              ram_addr_q   <= pend_word_q;
              ram_din_q    <= lane_mask(pend_data_q, pend_be_q);
              ram_be_q     <= pend_be_q;
              state_q      <= S_WRITE;
            end else begin
              pend_valid_q <= 1'b1;
              pend_word_q  <= in_word;
              pend_data_q  <= merge_data;
              pend_be_q    <= merge_be;
              if (merge_be == 2'b11) begin
                ram_req_q  <= 1'b1;
                wait_q     <= 1'b1;
                ram_addr_q <= in_word;
                ram_din_q  <= merge_data;
                ram_be_q   <= 2'b11;
                state_q    <= S_WRITE;
              end
            end
          end else if (!ioctl_download || fall_q) begin
            fall_q <= 1'b0;
            if (pend_valid_q) begin
              ram_req_q  <= 1'b1;
              wait_q     <= 1'b1;
              ram_addr_q <= pend_word_q;
              ram_din_q  <= lane_mask(pend_data_q, pend_be_q);
              ram_be_q   <= pend_be_q;
              state_q    <= S_FINAL;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          // A download end seen mid-write is replayed once back in COLLECT.
          if (!ioctl_download) fall_q <= 1'b1;
          if (ram_ack) begin
            ram_req_q <= 1'b0;
            wait_q    <= 1'b0;
            state_q   <= S_COLLECT;
            if (hold_valid_q) begin
              hold_valid_q <= 1'b0;
              pend_valid_q <= 1'b1;
              pend_word_q  <= hold_word_q;
              pend_data_q  <= hold_lane_q ? {hold_byte_q, 8'h00} : {8'h00, hold_byte_q};
              pend_be_q    <= hold_lane_q ? 2'b10 : 2'b01;
            end else begin
              pend_valid_q <= 1'b0;
              pend_data_q  <= '0;
              pend_be_q    <= '0;
            end
          end
        end
        S_FINAL: begin
          if (ram_ack) begin
            ram_req_q    <= 1'b0;
            wait_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_be_q    <= '0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ioctl_wait = wait_q;
  assign ram_req    = ram_req_q;
  assign ram_we     = ram_req_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_be     = ram_be_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// tb/tb_ioctl_sdram_loader.sv - scoreboard bench for ioctl_sdram_loader
module tb_ioctl_sdram_loader;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        ram_req;
  logic        ram_ack = 1'b0;
  logic        ram_we;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_be;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [26:0] byte_count;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  done_cnt = 0;
  int  ack_delay = 0;
  bit  skip_dur = 1'b0;
  wr_t exp_q[$];

  ioctl_sdram_loader #(.ADDR_W(24), .BASE_WORD(24'd0)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_be(ram_be), .busy(busy), .done(done), .overrun(overrun),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // SDRAM model: acknowledges each request after ack_delay extra cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (ram_req) begin
        repeat (ack_delay) @(negedge clk);
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
      end
    end
  end

  // Monitor: pops expected writes on each new request and checks hold/duration.
  wr_t snap;
  bit  prev_req = 1'b0;
  int  hi_cnt = 0;
  always @(negedge clk) begin
    if (ram_req) begin
      if (!prev_req) begin
        hi_cnt = 1;
        snap = '{addr: ram_addr, din: ram_din, be: ram_be};
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", {8'h0, ram_addr}, 32'hFFFFFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {8'h0, ram_addr}, {8'h0, e.addr});
          chk("wr_din", {16'h0, ram_din}, {16'h0, e.din});
          chk("wr_be", {30'h0, ram_be}, {30'h0, e.be});
        end
      end else begin
        hi_cnt++;
        if ({ram_addr, ram_din, ram_be} !== {snap.addr, snap.din, snap.be})
          chk("wr_stable", {8'h0, ram_addr}, {8'h0, snap.addr});
      end
    end else if (prev_req && !skip_dur) begin
      chk("req_cycles", hi_cnt, ack_delay + 1);
    end
    if (ram_we !== ram_req) chk("we_eq_req", {31'h0, ram_we}, {31'h0, ram_req});
    if (ioctl_wait !== ram_req) chk("wait_eq_req", {31'h0, ioctl_wait}, {31'h0, ram_req});
    if (done) done_cnt++;
    prev_req = ram_req;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_timeout", 32'(n), 32'd0);
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    wait_ready();
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl;
    ioctl_download = 1'b1;
    tick();
    chk("busy_start", {31'h0, busy}, 32'd1);
    chk("count_start", {5'h0, byte_count}, 32'd0);
  endtask

  task automatic wait_done(input int exp_count);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("done_pulses", done_cnt - start, 32'd1);
    chk("busy_after_done", {31'h0, busy}, 32'd0);
    chk("byte_count", {5'h0, byte_count}, exp_count);
  endtask

  task automatic end_dl(input int exp_count);
    wait_ready();
    ioctl_download = 1'b0;
    wait_done(exp_count);
  endtask

  task automatic push(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_q.push_back('{addr: a, din: d, be: be});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_req", {31'h0, ram_req}, 32'd0);
    chk("rst_wait", {31'h0, ioctl_wait}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_overrun", {31'h0, overrun}, 32'd0);
    chk("rst_count", {5'h0, byte_count}, 32'd0);
    chk("rst_bus", {ram_addr[7:0], ram_din, 6'h0, ram_be}, 32'd0);

    // Sequential download
    push(24'd0, 16'hBBAA, 2'b11);
    push(24'd1, 16'hDDCC, 2'b11);
    start_dl();
    send_byte(27'd0, 8'hAA);
    send_byte(27'd1, 8'hBB);
    send_byte(27'd2, 8'hCC);
    send_byte(27'd3, 8'hDD);
    end_dl(4);

    // Odd length, trailing partial word flushed at download end
    push(24'd0, 16'h2211, 2'b11);
    push(24'd1, 16'h0033, 2'b01);
    start_dl();
    send_byte(27'd0, 8'h11);
    send_byte(27'd1, 8'h22);
    send_byte(27'd2, 8'h33);
    end_dl(3);

    // Non-sequential: second byte forces flush of first and is held
    push(24'h8, 16'h0055, 2'b01);
    push(24'h10, 16'h6600, 2'b10);
    start_dl();
    send_byte(27'h10, 8'h55);
    send_byte(27'h21, 8'h66);
    end_dl(2);

    // Slow ack
    ack_delay = 10;
    push(24'd0, 16'h0201, 2'b11);
    start_dl();
    send_byte(27'd0, 8'h01);
    send_byte(27'd1, 8'h02);
    end_dl(2);

    // Reset while a request is outstanding
    ack_delay = 5;
    push(24'd0, 16'h8877, 2'b11);
    start_dl();
    send_byte(27'd0, 8'h77);
    send_byte(27'd1, 8'h88);
    chk("req_before_reset", {31'h0, ram_req}, 32'd1);
    skip_dur = 1'b1;
    reset = 1'b1;
    tick();
    chk("mid_rst_req", {31'h0, ram_req}, 32'd0);
    chk("mid_rst_wait", {31'h0, ioctl_wait}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    chk("mid_rst_count", {5'h0, byte_count}, 32'd0);
    chk("mid_rst_bus", {ram_addr[7:0], ram_din, 6'h0, ram_be}, 32'd0);
    reset = 1'b0;
    tick();
    chk("restart_busy", {31'h0, busy}, 32'd1);
    ioctl_download = 1'b0;
    wait_done(0);
    repeat (10) tick();
    skip_dur = 1'b0;
    ack_delay = 0;
    push(24'd2, 16'hBC9A, 2'b11);
    start_dl();
    send_byte(27'd4, 8'h9A);
    send_byte(27'd5, 8'hBC);
    end_dl(2);

    // Overrun: byte pushed while ioctl_wait is high
    ack_delay = 6;
    push(24'd0, 16'h2010, 2'b11);
    start_dl();
    send_byte(27'd0, 8'h10);
    send_byte(27'd1, 8'h20);
    chk("wait_high", {31'h0, ioctl_wait}, 32'd1);
    ioctl_addr = 27'd2;
    ioctl_dout = 8'h99;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    chk("overrun_set", {31'h0, overrun}, 32'd1);
    end_dl(2);
    chk("overrun_sticky", {31'h0, overrun}, 32'd1);
    ack_delay = 0;
    start_dl();
    chk("overrun_cleared", {31'h0, overrun}, 32'd0);
    end_dl(0);

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
